pc_sequencer: RTL and testbench

Sequential program-counter controller for the philv core. It owns the architectural PC register and issues instruction-fetch requests to instruction memory over a req/ack handshake. It holds each fetched instruction while it executes, then advances the PC by +4 or redirects it to a jump or branch target, as selected by the executing instruction's opcode and the branch outcome. It sits between instruction memory, the decoder and the execute stage, and replaces free-running PC updates with an explicit fetch/execute sequence.

---
 rtl/pc_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Program-counter controller for the philv core. It owns the architectural
//   PC and runs an explicit IDLE -> FETCH -> EXEC sequence. It issues fetch
//   requests to instruction memory, holds the returned instruction while it
//   executes, and then advances the PC by +4 or loads it from a jump or
//   branch target.
//
// Optional feature:
//   PC_MISALIGN_TRAP_EN
//     Defined: a redirect to a target with target[1:0] != 0 loads TRAP_VECTOR
//       and pulses trap instead of redirect.
//     Undefined: trap is tied low and target[1:0] is masked to 2'b00.
//
// Ports:
//   clk           core clock; every state update happens on the rising edge
//   rst           asynchronous, active-high reset
//   run           level; keep fetching while high
//   halt          pulse; enter HALT at the next instruction boundary
//   fetch_req     fetch request to instruction memory
//   fetch_addr    fetch address; always equal to pc
//   fetch_ack     instruction memory returned the instruction at fetch_addr
//   instr_valid   a fetched instruction is held for execute
//   opcode        opcode of the held instruction
//   branch_taken  ALU branch result; only used with the branch opcode
//   target        jump or branch target from execute
//   exec_done     execute finished the held instruction; only used in EXEC
//   pc            architectural PC
//   redirect      one-cycle pulse when pc is loaded from target
//   trap          one-cycle pulse on a misaligned target (optional feature)
// -----------------------------------------------------------------------------

`ifndef INSTR_OPCODE_WIDTH
`define INSTR_OPCODE_WIDTH 7
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL 7'b1101111
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR 7'b1100111
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH 7'b1100011
`endif

module pc_sequencer #(
  parameter int unsigned     N            = 32,
  parameter logic [N-1:0]    RESET_VECTOR = 32'h0000_0000,
  parameter logic [N-1:0]    TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  input  logic                           halt,
  output logic                           fetch_req,
  output logic [N-1:0]                   fetch_addr,
  input  logic                           fetch_ack,
  output logic                           instr_valid,
  input  logic [`INSTR_OPCODE_WIDTH-1:0] opcode,
  input  logic                           branch_taken,
  input  logic [N-1:0]                   target,
  input  logic                           exec_done,
  output logic [N-1:0]                   pc,
  output logic                           redirect,
  output logic                           trap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'd4};

  state_t         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic           halt_pending_q, halt_pending_d;
  logic           fetch_req_q, fetch_req_d;
  logic           instr_valid_q, instr_valid_d;
  logic           redirect_q, redirect_d;
  logic           take_target_s;
`ifdef PC_MISALIGN_TRAP_EN
  logic           trap_q, trap_d;
`else
  logic           unused_ok_s;
`endif

  // A control transfer happens on JAL, JALR, or a branch whose condition held;
  // branch_taken is meaningless for any other opcode.
  assign take_target_s = (opcode == `OPCODE_JAL) ||
                         (opcode == `OPCODE_JALR) ||
                         ((opcode == `OPCODE_BRANCH) && branch_taken);

  // Next-state, next-PC and next-output computation.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    // A halt pulse is remembered until reset, so it is honoured at the next
    // instruction boundary even if it arrives mid-fetch.
    halt_pending_d = halt_pending_q | halt;
    redirect_d     = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d         = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (halt_pending_d) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // pc (and therefore fetch_addr) is untouched here, so the address
        // stays stable for as long as the ack is withheld.
        if (fetch_ack) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          if (take_target_s) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
              pc_d   = TRAP_VECTOR;
              trap_d = 1'b1;
            end else begin
              pc_d       = target;
              redirect_d = 1'b1;
            end
`else
            pc_d       = {target[N-1:2], 2'b00};
            redirect_d = 1'b1;
`endif
          end else begin
            // Natural modulo-2^N wrap of the adder is the intended behaviour.
            pc_d = pc_q + PC_STEP;
          end

          if (halt_pending_d) begin
            state_d = ST_HALT;
          end else if (run) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so that they line up with
    // the state they describe.
    fetch_req_d   = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_EXEC);
  end

  // Sequencer state, PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_VECTOR;
      halt_pending_q <= 1'b0;
      fetch_req_q    <= 1'b0;
      instr_valid_q  <= 1'b0;
      redirect_q     <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      halt_pending_q <= halt_pending_d;
      fetch_req_q    <= fetch_req_d;
      instr_valid_q  <= instr_valid_d;
      redirect_q     <= redirect_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q         <= trap_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign fetch_addr  = pc_q;
  assign fetch_req   = fetch_req_q;
  assign instr_valid = instr_valid_q;
  assign redirect    = redirect_q;

`ifdef PC_MISALIGN_TRAP_EN
  assign trap = trap_q;
`else
  // Without the trap feature the low target bits and the trap vector have no
  // function.
  assign trap        = 1'b0;
  assign unused_ok_s = ^{target[1:0], TRAP_VECTOR};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
`ifndef INSTR_OPCODE_WIDTH
`define INSTR_OPCODE_WIDTH 7
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL 7'b1101111
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR 7'b1100111
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH 7'b1100011
`endif

module tb_pc_sequencer;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = `OPCODE_JAL;
  localparam logic [6:0] OP_JALR   = `OPCODE_JALR;
  localparam logic [6:0] OP_BRANCH = `OPCODE_BRANCH;

  logic        clk;
  logic        rst;
  logic        run;
  logic        halt;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic [31:0] target;
  logic        exec_done;
  logic [31:0] pc;
  logic        redirect;
  logic        trap;

  int total;
  int bad;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .halt         (halt),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .target       (target),
    .exec_done    (exec_done),
    .pc           (pc),
    .redirect     (redirect),
    .trap         (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) until fetch_req is seen at a falling edge.
  task automatic wait_fetch();
    int n;
    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL wait_fetch: fetch_req=%b after %0d cycles, required 1", fetch_req, n);
    end
  endtask

  // Fetches one instruction (ack in the request cycle) and executes it.
  // Returns at the falling edge just after the EXEC->exec_done transition.
  task automatic do_instr(input logic [6:0] opc, input logic [31:0] tgt, input logic tk);
    wait_fetch();
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack    = 1'b0;
    opcode       = opc;
    target       = tgt;
    branch_taken = tk;
    exec_done    = 1'b1;
    @(negedge clk);
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    opcode       = OP_ALU;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pc !== 32'h0 || fetch_req !== 1'b0 || instr_valid !== 1'b0 ||
        redirect !== 1'b0 || trap !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: pc=%h req=%b iv=%b rd=%b tr=%b, required 0 all",
               pc, fetch_req, instr_valid, redirect, trap);
    end
    rst = 1'b0;
    // exec_done in IDLE must not move the PC
    exec_done = 1'b1;
    opcode    = OP_JAL;
    target    = 32'h0000_0200;
    @(negedge clk);
    exec_done = 1'b0;
    opcode    = OP_ALU;
    total++;
    if (pc !== 32'h0 || fetch_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_exec_done: pc=%h req=%b, required 0/0", pc, fetch_req);
    end
  endtask

  task automatic test_sequential();
    run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fetch_req !== 1'b1 || fetch_addr !== 32'(4 * i)) begin
        bad++;
        $display("FAIL seq_fetch[%0d]: req=%b addr=%h, required 1/%h",
                 i, fetch_req, fetch_addr, 32'(4 * i));
      end
      fetch_ack = 1'b1;
      @(negedge clk);
      fetch_ack = 1'b0;
      total++;
      if (instr_valid !== 1'b1 || fetch_req !== 1'b0) begin
        bad++;
        $display("FAIL seq_exec[%0d]: iv=%b req=%b, required 1/0", i, instr_valid, fetch_req);
      end
      opcode    = OP_ALU;
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      total++;
      if (redirect !== 1'b0 || pc !== 32'(4 * (i + 1))) begin
        bad++;
        $display("FAIL seq_pc[%0d]: pc=%h redirect=%b, required %h/0",
                 i, pc, redirect, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_jal();
    total++;
    if (pc !== 32'h10) begin
      bad++;
      $display("FAIL jal_start_pc: pc=%h, required 00000010", pc);
    end
    do_instr(OP_JAL, 32'h40, 1'b0);
    total++;
    if (redirect !== 1'b1 || pc !== 32'h40 || fetch_req !== 1'b1 || fetch_addr !== 32'h40) begin
      bad++;
      $display("FAIL jal_redirect: rd=%b pc=%h req=%b addr=%h, required 1/40/1/40",
               redirect, pc, fetch_req, fetch_addr);
    end
    @(negedge clk);
    total++;
    if (redirect !== 1'b0 || fetch_addr !== 32'h40) begin
      bad++;
      $display("FAIL jal_pulse_width: rd=%b addr=%h, required 0/40", redirect, fetch_addr);
    end
  endtask

  task automatic test_branch();
    do_instr(OP_JAL, 32'h20, 1'b0);
    do_instr(OP_BRANCH, 32'h80, 1'b0);
    total++;
    if (pc !== 32'h24 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL branch_not_taken: pc=%h rd=%b, required 24/0", pc, redirect);
    end
    do_instr(OP_JAL, 32'h20, 1'b0);
    do_instr(OP_BRANCH, 32'h80, 1'b1);
    total++;
    if (pc !== 32'h80 || redirect !== 1'b1) begin
      bad++;
      $display("FAIL branch_taken: pc=%h rd=%b, required 80/1", pc, redirect);
    end
    do_instr(OP_ALU, 32'h200, 1'b1);
    total++;
    if (pc !== 32'h84 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL taken_non_branch: pc=%h rd=%b, required 84/0", pc, redirect);
    end
  endtask

  task automatic test_wrap();
    do_instr(OP_JALR, 32'hFFFF_FFFC, 1'b0);
    do_instr(OP_ALU, 32'h0, 1'b0);
    total++;
    if (pc !== 32'h0 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL pc_wrap: pc=%h rd=%b, required 00000000/0", pc, redirect);
    end
  endtask

  task automatic test_stall_halt();
    do_instr(OP_JAL, 32'h8, 1'b0);
    wait_fetch();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (fetch_req !== 1'b1 || fetch_addr !== 32'h8 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall[%0d]: req=%b addr=%h iv=%b, required 1/8/0",
                 k, fetch_req, fetch_addr, instr_valid);
      end
      halt = (k == 1);
      @(negedge clk);
    end
    halt      = 1'b0;
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL halt_exec: iv=%b, required 1", instr_valid);
    end
    opcode    = OP_ALU;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    // run is still high: HALT must win and stay
    opcode    = OP_JAL;
    target    = 32'h200;
    fetch_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exec_done = 1'b1;
      total++;
      if (pc !== 32'hC || fetch_req !== 1'b0 || instr_valid !== 1'b0 || redirect !== 1'b0) begin
        bad++;
        $display("FAIL halted[%0d]: pc=%h req=%b iv=%b rd=%b, required C/0/0/0",
                 k, pc, fetch_req, instr_valid, redirect);
      end
      @(negedge clk);
    end
    exec_done = 1'b0;
    fetch_ack = 1'b0;
    opcode    = OP_ALU;
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    do_instr(OP_JAL, 32'h30, 1'b0);
    wait_fetch();
    total++;
    if (fetch_addr !== 32'h30) begin
      bad++;
      $display("FAIL pre_reset_addr: addr=%h, required 30", fetch_addr);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (fetch_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: req=%b pc=%h iv=%b, required 0/0/0", fetch_req, pc, instr_valid);
    end
    run       = 1'b0;
    fetch_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
        bad++;
        $display("FAIL late_ack[%0d]: req=%b iv=%b pc=%h, required 0/0/0",
                 k, fetch_req, instr_valid, pc);
      end
    end
    fetch_ack = 1'b0;
  endtask

  task automatic test_halt_idle();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    run  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (fetch_req !== 1'b0 || pc !== 32'h0) begin
        bad++;
        $display("FAIL halt_from_idle[%0d]: req=%b pc=%h, required 0/0", k, fetch_req, pc);
      end
    end
  endtask

  task automatic test_misalign();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    do_instr(OP_JALR, 32'h42, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    total++;
    if (pc !== 32'h100 || trap !== 1'b1 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL misalign_trap: pc=%h tr=%b rd=%b, required 100/1/0", pc, trap, redirect);
    end
`else
    total++;
    if (pc !== 32'h40 || trap !== 1'b0 || redirect !== 1'b1) begin
      bad++;
      $display("FAIL misalign_mask: pc=%h tr=%b rd=%b, required 40/0/1", pc, trap, redirect);
    end
`endif
    @(negedge clk);
    total++;
    if (trap !== 1'b0 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL misalign_pulse: tr=%b rd=%b, required 0/0", trap, redirect);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    run          = 1'b0;
    halt         = 1'b0;
    fetch_ack    = 1'b0;
    opcode       = OP_ALU;
    branch_taken = 1'b0;
    target       = 32'h0;
    exec_done    = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_wrap();
    test_stall_halt();
    test_reset_mid_fetch();
    test_halt_idle();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
